// File: rtl/fp16_job_sequencer.sv
// Moves one FP16 batch job from BRAM into the compute engine and writes the
// engine results back to BRAM. When the job completes, tx_en is raised for the UART.
module fp16_job_sequencer #(
   parameter int unsigned ADDR_W         = 12,
   parameter int unsigned DATA_W         = 64,
   parameter int unsigned SRC_BASE       = 0,
   parameter int unsigned DST_BASE       = 1024,
   parameter int unsigned WORDS_PER_CASE = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [7:0]        case_num_i,
   output logic              rd_en_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   input  logic [DATA_W-1:0] rd_data_i,
   output logic              eng_in_valid_o,
   input  logic              eng_in_ready_i,
   output logic [DATA_W-1:0] eng_in_data_o,
   input  logic              eng_out_valid_i,
   input  logic [DATA_W-1:0] eng_out_data_i,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [DATA_W-1:0] wr_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              tx_en_o,
   output logic              ovf_err_o
);

   localparam logic [ADDR_W-1:0] SRC_A = ADDR_W'(SRC_BASE);
   localparam logic [ADDR_W-1:0] DST_A = ADDR_W'(DST_BASE);
   localparam logic [ADDR_W-1:0] WPC_A = ADDR_W'(WORDS_PER_CASE);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   total_q, issued_q, written_q;
   logic                rd_pending_q;
   logic [1:0]          buf_cnt_q;
   logic [DATA_W-1:0]   buf0_q, buf1_q;
   logic                wr_en_q, tx_en_q, ovf_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [DATA_W-1:0]   wr_data_q;

   logic                start_acc_s, rd_en_s, push_s, pop_s, wr_acc_s, active_s;
   logic [ADDR_W-1:0]   total_s;

   assign total_s  = ADDR_W'(case_num_i) * WPC_A;
   assign active_s = (state_q == S_FETCH) || (state_q == S_DRAIN);
   assign push_s   = rd_pending_q;
   assign pop_s    = (buf_cnt_q != 2'd0) && eng_in_ready_i;
   assign wr_acc_s = eng_out_valid_i && active_s && (written_q < total_q);

   // Next-state decode and read-issue strobe
   always_comb begin
      state_d     = state_q;
      start_acc_s = 1'b0;
      rd_en_s     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               start_acc_s = 1'b1;
               state_d     = (total_s == '0) ? S_DONE : S_FETCH;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FETCH: begin
            // Pending read counts as occupied so a 2-entry skid can never overflow.
            rd_en_s = (issued_q < total_q) &&
                      (({1'b0, buf_cnt_q} + {2'b00, rd_pending_q}) < 3'd2);
            if (issued_q == total_q) begin
               state_d = S_DRAIN;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DRAIN: begin
            if (written_q == total_q) begin
               state_d = S_DONE;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, job counters and status flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         total_q      <= '0;
         issued_q     <= '0;
         written_q    <= '0;
         rd_pending_q <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         tx_en_q      <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         rd_pending_q <= rd_en_s;
         wr_en_q      <= wr_acc_s;
         if (start_acc_s) begin
            total_q   <= total_s;
            issued_q  <= '0;
            written_q <= '0;
         end else begin
            if (rd_en_s) issued_q <= issued_q + ADDR_W'(1);
            if (wr_acc_s) written_q <= written_q + ADDR_W'(1);
         end
         if (wr_acc_s) begin
            wr_addr_q <= DST_A + written_q;
            wr_data_q <= eng_out_data_i;
         end
         // tx_en rises together with done and drops on the next accepted start.
         if (state_d == S_DONE) begin
            tx_en_q <= 1'b1;
         end else if (start_acc_s) begin
            tx_en_q <= 1'b0;
         end
         if (eng_out_valid_i && !wr_acc_s) ovf_q <= 1'b1;
      end
   end

   // Two-entry skid buffer between BRAM read data and engine input
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         buf_cnt_q <= 2'd0;
         buf0_q    <= '0;
         buf1_q    <= '0;
      end else begin
         case ({push_s, pop_s})
            2'b10: begin
               if (buf_cnt_q == 2'd0) buf0_q <= rd_data_i;
               else                   buf1_q <= rd_data_i;
               buf_cnt_q <= buf_cnt_q + 2'd1;
            end
            2'b01: begin
               buf0_q    <= buf1_q;
               buf_cnt_q <= buf_cnt_q - 2'd1;
            end
            2'b11: begin
               if (buf_cnt_q == 2'd1) begin
                  buf0_q <= rd_data_i;
               end else begin
                  buf0_q <= buf1_q;
                  buf1_q <= rd_data_i;
               end
            end
            default: buf_cnt_q <= buf_cnt_q;
         endcase
      end
   end

   assign rd_en_o        = rd_en_s;
   assign rd_addr_o      = rd_en_s ? (SRC_A + issued_q) : '0;
   assign eng_in_valid_o = (buf_cnt_q != 2'd0);
   assign eng_in_data_o  = buf0_q;
   assign wr_en_o        = wr_en_q;
   assign wr_addr_o      = wr_addr_q;
   assign wr_data_o      = wr_data_q;
   assign busy_o         = active_s;
   assign done_o         = (state_q == S_DONE);
   assign tx_en_o        = tx_en_q;
   assign ovf_err_o      = ovf_q;

endmodule

// File: tb/tb_fp16_job_sequencer.sv
// Directed bench for fp16_job_sequencer: BRAM and 3-cycle echo engine models,
// with a negedge monitor that logs reads, writes, and engine handshakes.
module tb_fp16_job_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i;
   logic [7:0]  case_num_i;
   logic        rd_en_o;
   logic [11:0] rd_addr_o;
   logic [63:0] rd_data_i = '0;
   logic        eng_in_valid_o;
   logic        eng_in_ready_i = 1'b0;
   logic [63:0] eng_in_data_o;
   logic        eng_out_valid_i;
   logic [63:0] eng_out_data_i;
   logic        wr_en_o;
   logic [11:0] wr_addr_o;
   logic [63:0] wr_data_o;
   logic        busy_o, done_o, tx_en_o, ovf_err_o;

   int checks = 0;
   int errors = 0;

   logic [63:0] mem [0:4095];
   logic [11:0] rd_log [$];
   logic [11:0] wa_log [$];
   logic [63:0] wd_log [$];
   logic [63:0] acc_log [$];
   int          done_cnt = 0, stall_viol = 0, rd_tot = 0, acc_tot = 0, max_occ = 0;
   bit          stalled_prev = 1'b0;
   logic [63:0] stall_data = '0;

   bit          rand_ready = 1'b0;
   logic        ready_level = 1'b1;
   logic        man_valid = 1'b0;
   logic [63:0] man_data = '0;
   logic        pv [0:2] = '{1'b0, 1'b0, 1'b0};
   logic [63:0] pd [0:2] = '{64'd0, 64'd0, 64'd0};

   always #5 clk = ~clk;

   fp16_job_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .case_num_i(case_num_i),
      .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
      .eng_in_valid_o(eng_in_valid_o), .eng_in_ready_i(eng_in_ready_i),
      .eng_in_data_o(eng_in_data_o), .eng_out_valid_i(eng_out_valid_i),
      .eng_out_data_i(eng_out_data_i), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
      .wr_data_o(wr_data_o), .busy_o(busy_o), .done_o(done_o), .tx_en_o(tx_en_o),
      .ovf_err_o(ovf_err_o)
   );

   // BRAM read port: data one cycle after rd_en
   always @(posedge clk) begin
      if (rd_en_o) rd_data_i <= mem[rd_addr_o];
   end

   // Engine: echoes each accepted word three cycles later; reset with the DUT
   always @(posedge clk) begin
      if (!rst_n) begin
         pv[0] <= 1'b0; pv[1] <= 1'b0; pv[2] <= 1'b0;
      end else begin
         pv[0] <= eng_in_valid_o && eng_in_ready_i;
         pd[0] <= eng_in_data_o;
         pv[1] <= pv[0]; pd[1] <= pd[0];
         pv[2] <= pv[1]; pd[2] <= pd[1];
      end
   end
   assign eng_out_valid_i = pv[2] | man_valid;
   assign eng_out_data_i  = pv[2] ? pd[2] : man_data;

   // Ready driver: fixed level or random per cycle, changed well after the edge
   always @(posedge clk) begin
      #2;
      eng_in_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
   end

   // Monitor: log DUT activity mid-cycle
   always @(negedge clk) begin
      if (!rst_n) begin
         rd_tot = 0;
         acc_tot = 0;
         stalled_prev = 1'b0;
      end else begin
         if (rd_en_o) begin
            rd_log.push_back(rd_addr_o);
            rd_tot++;
         end
         if (rd_tot - acc_tot > max_occ) max_occ = rd_tot - acc_tot;
         if (eng_in_valid_o && eng_in_ready_i) begin
            acc_log.push_back(eng_in_data_o);
            acc_tot++;
         end
         if (wr_en_o) begin
            wa_log.push_back(wr_addr_o);
            wd_log.push_back(wr_data_o);
         end
         if (done_o) done_cnt++;
         if (stalled_prev && eng_in_valid_o && (eng_in_data_o !== stall_data)) stall_viol++;
         stalled_prev = eng_in_valid_o && !eng_in_ready_i;
         stall_data   = eng_in_data_o;
      end
   end

   // Number of read/write log entries since the given bases that differ from a
   // job of n words starting at address 0 and writing to 1024.
   function automatic int rw_bad(input int rb, input int wb, input int n);
      int bad = 0;
      for (int i = 0; i < n; i++) begin
         if (rb + i >= rd_log.size() || rd_log[rb + i] !== 12'(i)) bad++;
         if (wb + i >= wa_log.size() || wa_log[wb + i] !== 12'(1024 + i)) bad++;
         if (wb + i >= wd_log.size() || wd_log[wb + i] !== mem[i]) bad++;
      end
      return bad;
   endfunction

   task automatic start_job(input logic [7:0] n);
      @(negedge clk);
      case_num_i = n;
      start_i    = 1'b1;
      @(negedge clk);
      start_i    = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (done_o) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      logic [158:0] outs;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      outs = {rd_en_o, rd_addr_o, eng_in_valid_o, eng_in_data_o, wr_en_o, wr_addr_o,
              wr_data_o, busy_o, done_o, tx_en_o, ovf_err_o};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h, expected all zero", outs);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy_o, rd_en_o, done_o, tx_en_o} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_idle: busy/rd_en/done/tx_en got %b, expected 0000",
                  {busy_o, rd_en_o, done_o, tx_en_o});
      end
   endtask

   task automatic test_single_case();
      int rb = rd_log.size(), wb = wa_log.size(), d0 = done_cnt, bad;
      bit seen;
      ready_level = 1'b1;
      start_job(8'd1);
      checks++;
      if (busy_o !== 1'b1) begin errors++; $display("FAIL t1_busy: got %b, expected 1", busy_o); end
      wait_done(300, seen);
      checks++;
      if (!seen) begin errors++; $display("FAIL t1_done_timeout: done not seen within 300 cycles"); end
      repeat (2) @(negedge clk);
      checks++;
      if (rd_log.size() - rb != 16) begin errors++; $display("FAIL t1_reads: got %0d, expected 16", rd_log.size() - rb); end
      checks++;
      if (wa_log.size() - wb != 16) begin errors++; $display("FAIL t1_writes: got %0d, expected 16", wa_log.size() - wb); end
      bad = rw_bad(rb, wb, 16);
      checks++;
      if (bad != 0) begin errors++; $display("FAIL t1_addr_data: %0d bad entries, expected 0", bad); end
      checks++;
      if (done_cnt - d0 != 1) begin errors++; $display("FAIL t1_done_count: got %0d, expected 1", done_cnt - d0); end
      checks++;
      if ({tx_en_o, busy_o, ovf_err_o} !== 3'b100) begin
         errors++;
         $display("FAIL t1_status: tx_en/busy/ovf got %b, expected 100", {tx_en_o, busy_o, ovf_err_o});
      end
   endtask

   task automatic test_zero_case();
      int rb = rd_log.size(), wb = wa_log.size(), d0 = done_cnt;
      start_job(8'd0);
      checks++;
      if (done_o !== 1'b1) begin errors++; $display("FAIL t2_done_timing: got %b, expected 1", done_o); end
      @(negedge clk);
      checks++;
      if ({done_o, tx_en_o} !== 2'b01) begin
         errors++;
         $display("FAIL t2_after_done: done/tx_en got %b, expected 01", {done_o, tx_en_o});
      end
      repeat (5) @(negedge clk);
      checks++;
      if (rd_log.size() != rb || wa_log.size() != wb) begin
         errors++;
         $display("FAIL t2_no_access: reads %0d writes %0d, expected 0 0", rd_log.size() - rb, wa_log.size() - wb);
      end
      checks++;
      if (done_cnt - d0 != 1) begin errors++; $display("FAIL t2_done_count: got %0d, expected 1", done_cnt - d0); end
   endtask

   task automatic test_random_ready();
      int rb = rd_log.size(), wb = wa_log.size(), ab = acc_log.size(), d0 = done_cnt, bad = 0;
      bit seen;
      rand_ready = 1'b1;
      start_job(8'd2);
      checks++;
      if (tx_en_o !== 1'b0) begin errors++; $display("FAIL t3_tx_clear: got %b, expected 0", tx_en_o); end
      wait_done(2000, seen);
      rand_ready = 1'b0;
      checks++;
      if (!seen) begin errors++; $display("FAIL t3_done_timeout: done not seen within 2000 cycles"); end
      repeat (2) @(negedge clk);
      checks++;
      if (acc_log.size() - ab != 32) begin errors++; $display("FAIL t3_accepted: got %0d, expected 32", acc_log.size() - ab); end
      for (int i = 0; i < 32; i++)
         if (ab + i >= acc_log.size() || acc_log[ab + i] !== mem[i]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL t3_order: %0d words out of order or missing, expected 0", bad); end
      checks++;
      if (wa_log.size() - wb != 32) begin errors++; $display("FAIL t3_writes: got %0d, expected 32", wa_log.size() - wb); end
      bad = rw_bad(rb, wb, 32);
      checks++;
      if (bad != 0) begin errors++; $display("FAIL t3_addr_data: %0d bad entries, expected 0", bad); end
      checks++;
      if (stall_viol != 0) begin errors++; $display("FAIL t3_stall_stable: %0d changes while stalled, expected 0", stall_viol); end
      checks++;
      if (max_occ > 2) begin errors++; $display("FAIL t3_occupancy: max %0d, expected <= 2", max_occ); end
      checks++;
      if (done_cnt - d0 != 1) begin errors++; $display("FAIL t3_done_count: got %0d, expected 1", done_cnt - d0); end
   endtask

   task automatic test_restart_ignored();
      int rb = rd_log.size(), wb = wa_log.size(), d0 = done_cnt, bad;
      bit seen;
      start_job(8'd1);
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b1) begin errors++; $display("FAIL t4_busy: got %b, expected 1", busy_o); end
      case_num_i = 8'd3;
      start_i    = 1'b1;
      @(negedge clk);
      start_i    = 1'b0;
      wait_done(300, seen);
      checks++;
      if (!seen) begin errors++; $display("FAIL t4_done_timeout: done not seen within 300 cycles"); end
      repeat (20) @(negedge clk);
      checks++;
      if (rd_log.size() - rb != 16 || wa_log.size() - wb != 16) begin
         errors++;
         $display("FAIL t4_counts: reads %0d writes %0d, expected 16 16", rd_log.size() - rb, wa_log.size() - wb);
      end
      bad = rw_bad(rb, wb, 16);
      checks++;
      if (bad != 0) begin errors++; $display("FAIL t4_addr_data: %0d bad entries, expected 0", bad); end
      checks++;
      if (done_cnt - d0 != 1 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL t4_done_idle: done count %0d busy %b, expected 1 0", done_cnt - d0, busy_o);
      end
   endtask

   task automatic test_reset_mid_drain();
      int rb = rd_log.size(), wb = wa_log.size(), d0, bad, k;
      bit seen;
      logic [158:0] outs;
      start_job(8'd2);
      k = 0;
      while (rd_log.size() - rb < 32 && k < 500) begin
         @(negedge clk);
         k++;
      end
      repeat (2) @(negedge clk);
      checks++;
      if (busy_o !== 1'b1 || wa_log.size() - wb >= 32) begin
         errors++;
         $display("FAIL t5_mid_drain: busy %b writes %0d, expected 1 and < 32", busy_o, wa_log.size() - wb);
      end
      rst_n = 1'b0;
      @(negedge clk);
      outs = {rd_en_o, rd_addr_o, eng_in_valid_o, eng_in_data_o, wr_en_o, wr_addr_o,
              wr_data_o, busy_o, done_o, tx_en_o, ovf_err_o};
      checks++;
      if (outs !== '0) begin errors++; $display("FAIL t5_reset_outputs: got %h, expected all zero", outs); end
      rst_n = 1'b1;
      rb = rd_log.size();
      wb = wa_log.size();
      repeat (10) @(negedge clk);
      checks++;
      if (rd_log.size() != rb || wa_log.size() != wb) begin
         errors++;
         $display("FAIL t5_no_access: reads %0d writes %0d after reset, expected 0 0", rd_log.size() - rb, wa_log.size() - wb);
      end
      d0 = done_cnt;
      start_job(8'd1);
      wait_done(300, seen);
      checks++;
      if (!seen) begin errors++; $display("FAIL t5_done_timeout: done not seen within 300 cycles"); end
      repeat (2) @(negedge clk);
      bad = rw_bad(rb, wb, 16);
      checks++;
      if (bad != 0 || wa_log.size() - wb != 16) begin
         errors++;
         $display("FAIL t5_rerun: %0d bad entries, %0d writes, expected 0 and 16", bad, wa_log.size() - wb);
      end
      checks++;
      if (done_cnt - d0 != 1 || tx_en_o !== 1'b1) begin
         errors++;
         $display("FAIL t5_rerun_done: done count %0d tx_en %b, expected 1 1", done_cnt - d0, tx_en_o);
      end
   endtask

   task automatic test_ovf_idle();
      int wb = wa_log.size();
      bit seen;
      checks++;
      if (ovf_err_o !== 1'b0) begin errors++; $display("FAIL t6_ovf_initial: got %b, expected 0", ovf_err_o); end
      @(negedge clk);
      man_data  = 64'hDEAD_BEEF_0123_4567;
      man_valid = 1'b1;
      @(negedge clk);
      man_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (wa_log.size() != wb) begin errors++; $display("FAIL t6_no_write: got %0d writes, expected 0", wa_log.size() - wb); end
      checks++;
      if (ovf_err_o !== 1'b1) begin errors++; $display("FAIL t6_ovf_set: got %b, expected 1", ovf_err_o); end
      start_job(8'd1);
      wait_done(300, seen);
      repeat (10) @(negedge clk);
      checks++;
      if (ovf_err_o !== 1'b1 || wa_log.size() - wb != 16) begin
         errors++;
         $display("FAIL t6_ovf_sticky: ovf %b writes %0d, expected 1 16", ovf_err_o, wa_log.size() - wb);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (ovf_err_o !== 1'b0) begin errors++; $display("FAIL t6_ovf_reset: got %b, expected 0", ovf_err_o); end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++)
         mem[i] = {16'hF00D ^ 16'(i), 16'(i), 32'(i * 40503 + 1)};
      rst_n      = 1'b0;
      start_i    = 1'b0;
      case_num_i = 8'd0;
      repeat (2) @(negedge clk);
      test_reset();
      test_single_case();
      test_zero_case();
      test_random_ready();
      test_restart_ignored();
      test_reset_mid_drain();
      test_ovf_idle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
